pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Combines the global start signal, load-use hazard detection, ID-stage branch flush and data-cache miss stalls into the enables that drive the PC, IF/ID, ID/EX and the downstream pipeline registers. Drives the ID/EX `start_i` input: a low level loads zeros into ID/EX, which inserts a bubble. Also keeps a stall watchdog and, optionally, saturating performance counters.

## Interface
- `STALL_LIMIT`, default 255: consecutive mem-stall cycles before `timeout_o` sets; legal range 1..65535.
- `CNT_W`, default 16: width of the performance counters.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  CPU run enable; low forces IDLE.
- `ID_RS1addr_i`  in  5  rs1 of the instruction in ID.
- `ID_RS2addr_i`  in  5  rs2 of the instruction in ID.
- `ID_uses_rs2_i`  in  1  instruction in ID reads rs2.
- `EX_MemRead_i`  in  1  instruction in EX is a load.
- `EX_RDaddr_i`  in  5  rd of the instruction in EX.
- `ID_branch_taken_i`  in  1  branch resolved taken in ID.
- `mem_stall_i`  in  1  data cache busy; the pipeline must freeze while high.
- `PCWrite_o`  out  1  PC update enable.
- `IFID_write_o`  out  1  IF/ID load enable.
- `IFID_flush_o`  out  1  clear IF/ID to a NOP.
- `IDEX_start_o`  out  1  ID/EX `start_i`; 0 inserts a bubble.
- `pipe_hold_o`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `state_o`  out  2  FSM state: 00 IDLE, 01 RUN, 10 MEM_WAIT.
- `timeout_o`  out  1  sticky watchdog flag.
- `stall_cnt_o`, `bubble_cnt_o`, `flush_cnt_o`  out  CNT_W each  performance counters; present only with the macro.

## Operation
- Hazard term `lu` = `EX_MemRead_i` & (`EX_RDaddr_i` != 0) & ((`EX_RDaddr_i` == `ID_RS1addr_i`) | (`ID_uses_rs2_i` & (`EX_RDaddr_i` == `ID_RS2addr_i`))).
- FSM transitions:
  - any state with `start_i`=0 -> IDLE.
  - IDLE with `start_i`=1 -> RUN.
  - RUN with `mem_stall_i`=1 -> MEM_WAIT.
  - MEM_WAIT with `mem_stall_i`=0 -> RUN.
- Outputs are combinational from state and inputs. The highest-priority matching row applies:
  1. `start_i`=0 or state IDLE: PCWrite 0, IFID_write 0, IFID_flush 0, IDEX_start 0, pipe_hold 0.
  2. `mem_stall_i`=1: PCWrite 0, IFID_write 0, IFID_flush 0, IDEX_start 1, pipe_hold 1. Everything is frozen and no bubble is inserted.
  3. `lu`=1: PCWrite 0, IFID_write 0, IFID_flush 0, IDEX_start 0, pipe_hold 0. This is a one-cycle bubble. Load-use beats a branch because the branch operands are not valid yet.
  4. `ID_branch_taken_i`=1: PCWrite 1, IFID_write 1, IFID_flush 1, IDEX_start 1, pipe_hold 0.
  5. Otherwise: PCWrite 1, IFID_write 1, IFID_flush 0, IDEX_start 1, pipe_hold 0.
- Watchdog counter `wait_cnt`, width clog2(STALL_LIMIT+1):
  - increments each cycle with `start_i` & `mem_stall_i`, saturating at STALL_LIMIT;
  - clears on any cycle where `mem_stall_i`=0 or `start_i`=0.
- `timeout_o` sets on the edge that ends the STALL_LIMIT-th consecutive stalled cycle. Only reset clears it; `start_i`=0 does not.

## Timing
- Hazard, flush and stall responses take zero cycles: they are combinational in the same cycle as the input.
- `state_o` lags `mem_stall_i` and `start_i` by one cycle.
- Reset values: state IDLE; `wait_cnt` 0; `timeout_o` 0; all counters 0. Outputs follow row 1.
- Reset asserted mid-stall: all state clears immediately and asynchronously.
- `mem_stall_i` and `lu` together: the stall wins. On the first cycle after the stall drops, `lu` is re-evaluated and the bubble is still inserted.
- `mem_stall_i` and branch together: no flush occurs while stalled. The flush happens on the first unstalled cycle, provided `ID_branch_taken_i` is still high.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` counts cycles with `pipe_hold_o`=1;
  - `bubble_cnt_o` counts row-3 cycles;
  - `flush_cnt_o` counts row-4 cycles;
  - each counter saturates at all-ones and resets to 0.
- `PIPE_CTRL_PERF_EN` undefined: the three counter ports and their logic are absent.

## Test plan
- Reset low, then release with `start_i`=0 -> state_o=00, IDEX_start_o=0, PCWrite_o=0. Raise `start_i` -> state_o=01 next cycle; PCWrite_o=1 in that same cycle.
- EX_MemRead=1, EX_RD=5, ID_RS2=5, ID_uses_rs2=1 -> one cycle with PCWrite=0, IFID_write=0, IDEX_start=0. Repeat with EX_RD=0 -> no bubble.
- `ID_branch_taken_i`=1 with no hazard -> IFID_flush_o=1, PCWrite_o=1; with PERF_EN, flush_cnt_o=1 on the following cycle.
- `mem_stall_i` high for 3 cycles together with `lu`=1 -> pipe_hold_o=1 for 3 cycles and state_o=10; then one bubble cycle. With PERF_EN, stall_cnt_o=3 and bubble_cnt_o=1.
- STALL_LIMIT=4, `mem_stall_i` high for 4 cycles -> timeout_o=1 after the 4th edge. It stays 1 after the stall drops and after `start_i`=0; only rst_i low clears it.
- Assert rst_i low during MEM_WAIT -> state_o=00 and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Brief    : Hazard inputs and pipeline-enable outputs of pipe_hazard_ctrl.
//             Counter signals exist only with PIPE_CTRL_PERF_EN defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic       start_i;
    logic [4:0] ID_RS1addr_i;
    logic [4:0] ID_RS2addr_i;
    logic       ID_uses_rs2_i;
    logic       EX_MemRead_i;
    logic [4:0] EX_RDaddr_i;
    logic       ID_branch_taken_i;
    logic       mem_stall_i;
    logic       PCWrite_o;
    logic       IFID_write_o;
    logic       IFID_flush_o;
    logic       IDEX_start_o;
    logic       pipe_hold_o;
    logic [1:0] state_o;
    logic       timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] bubble_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, ID_RS1addr_i, ID_RS2addr_i, ID_uses_rs2_i,
               EX_MemRead_i, EX_RDaddr_i, ID_branch_taken_i, mem_stall_i,
        input  PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_start_o,
               pipe_hold_o, state_o, timeout_o,
               stall_cnt_o, bubble_cnt_o, flush_cnt_o
    );
    modport slave (
        input  start_i, ID_RS1addr_i, ID_RS2addr_i, ID_uses_rs2_i,
               EX_MemRead_i, EX_RDaddr_i, ID_branch_taken_i, mem_stall_i,
        output PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_start_o,
               pipe_hold_o, state_o, timeout_o,
               stall_cnt_o, bubble_cnt_o, flush_cnt_o
    );
`else
    modport master (
        output start_i, ID_RS1addr_i, ID_RS2addr_i, ID_uses_rs2_i,
               EX_MemRead_i, EX_RDaddr_i, ID_branch_taken_i, mem_stall_i,
        input  PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_start_o,
               pipe_hold_o, state_o, timeout_o
    );
    modport slave (
        input  start_i, ID_RS1addr_i, ID_RS2addr_i, ID_uses_rs2_i,
               EX_MemRead_i, EX_RDaddr_i, ID_branch_taken_i, mem_stall_i,
        output PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_start_o,
               pipe_hold_o, state_o, timeout_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : 5-stage pipeline sequencing: load-use bubble, branch flush,
//             D-cache stall freeze, stall watchdog. Optional saturating
//             performance counters under macro PIPE_CTRL_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    localparam int                  c_WAIT_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [c_WAIT_W-1:0] c_LIMIT    = c_WAIT_W'(STALL_LIMIT);
    localparam logic [c_WAIT_W-1:0] c_LIMIT_M1 = c_WAIT_W'(STALL_LIMIT - 1);

    if (STALL_LIMIT < 1 || STALL_LIMIT > 65535 || CNT_W < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: STALL_LIMIT or CNT_W out of range");
    end

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout;

    logic w_lu;
    logic w_row_idle;
    logic w_row_stall;
    logic w_row_bubble;
    logic w_row_flush;

    always_comb begin
        w_lu = bus.EX_MemRead_i && (bus.EX_RDaddr_i != 5'd0) &&
               ((bus.EX_RDaddr_i == bus.ID_RS1addr_i) ||
                (bus.ID_uses_rs2_i && (bus.EX_RDaddr_i == bus.ID_RS2addr_i)));
        w_row_idle   = !bus.start_i || (r_state == ST_IDLE);
        w_row_stall  = !w_row_idle && bus.mem_stall_i;
        // Load-use outranks the branch: the branch compare would use stale operands.
        w_row_bubble = !w_row_idle && !bus.mem_stall_i && w_lu;
        w_row_flush  = !w_row_idle && !bus.mem_stall_i && !w_lu && bus.ID_branch_taken_i;
    end

    assign bus.PCWrite_o    = !w_row_idle && !w_row_stall && !w_row_bubble;
    assign bus.IFID_write_o = !w_row_idle && !w_row_stall && !w_row_bubble;
    assign bus.IFID_flush_o = w_row_flush;
    assign bus.IDEX_start_o = !w_row_idle && !w_row_bubble;
    assign bus.pipe_hold_o  = w_row_stall;
    assign bus.state_o      = r_state;
    assign bus.timeout_o    = r_timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else if (!bus.start_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     r_state <= ST_RUN;
                ST_RUN:      if (bus.mem_stall_i)  r_state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (!bus.mem_stall_i) r_state <= ST_RUN;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    // Watchdog flag is sticky: only reset clears it, even across start_i drops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (bus.start_i && bus.mem_stall_i) begin
            if (r_wait_cnt != c_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt == c_LIMIT_M1) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_row_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_row_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
            if (w_row_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.bubble_cnt_o = r_bubble_cnt;
    assign bus.flush_cnt_o  = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed vectors for pipe_hazard_ctrl with a queue scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int STALL_LIMIT = 4;
    localparam int CNT_W       = 16;

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       stall;
        logic [4:0] outs;   // {PCWrite, IFID_write, IFID_flush, IDEX_start, pipe_hold}
        logic [1:0] st;
        logic       to;
        int         sc;
        int         bc;
        int         fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .STALL_LIMIT(STALL_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    task automatic add(input string nm, input logic rst, input logic start,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic stall, input logic [4:0] outs, input logic [1:0] st,
                       input logic to, input int sc, input int bc, input int fc);
        vec_t v;
        v.name = nm; v.rst = rst; v.start = start; v.rs1 = rs1; v.rs2 = rs2;
        v.uses = uses; v.mr = mr; v.rd = rd; v.br = br; v.stall = stall;
        v.outs = outs; v.st = st; v.to = to; v.sc = sc; v.bc = bc; v.fc = fc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input string sig, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s: got=%0d want=%0d", nm, sig, act, exp);
        end
    endtask

    // Driver: apply one vector per cycle just after the rising edge.
    initial begin
        bus.start_i = 1'b0; bus.ID_RS1addr_i = '0; bus.ID_RS2addr_i = '0;
        bus.ID_uses_rs2_i = 1'b0; bus.EX_MemRead_i = 1'b0; bus.EX_RDaddr_i = '0;
        bus.ID_branch_taken_i = 1'b0; bus.mem_stall_i = 1'b0;

        //   name               rst st rs1 rs2 u mr rd br sl outs      st    to sc bc fc
        add("rst_hold",          0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0);
        add("rst_rel_idle",      1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0);
        add("start_first",       1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0);
        add("run_normal",        1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2'b01, 0, 0, 0, 0);
        add("lu_rs2",            1, 1, 0, 5, 1, 1, 5, 0, 0, 5'b00000, 2'b01, 0, 0, 0, 0);
        add("lu_rd0",            1, 1, 0, 0, 1, 1, 0, 0, 0, 5'b11010, 2'b01, 0, 0, 1, 0);
        add("lu_rs1",            1, 1, 7, 0, 0, 1, 7, 0, 0, 5'b00000, 2'b01, 0, 0, 1, 0);
        add("rs2_unused",        1, 1, 3, 9, 0, 1, 9, 0, 0, 5'b11010, 2'b01, 0, 0, 2, 0);
        add("branch_flush",      1, 1, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 2'b01, 0, 0, 2, 0);
        add("after_flush",       1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2'b01, 0, 0, 2, 1);
        add("stall_lu_br_1",     1, 1, 0, 5, 1, 1, 5, 1, 1, 5'b00011, 2'b01, 0, 0, 2, 1);
        add("stall_lu_br_2",     1, 1, 0, 5, 1, 1, 5, 1, 1, 5'b00011, 2'b10, 0, 1, 2, 1);
        add("stall_lu_br_3",     1, 1, 0, 5, 1, 1, 5, 1, 1, 5'b00011, 2'b10, 0, 2, 2, 1);
        add("lu_after_stall",    1, 1, 0, 5, 1, 1, 5, 1, 0, 5'b00000, 2'b10, 0, 3, 2, 1);
        add("br_after_stall",    1, 1, 0, 0, 0, 0, 0, 1, 0, 5'b11110, 2'b01, 0, 3, 3, 1);
        add("run_again_1",       1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2'b01, 0, 3, 3, 2);
        add("wd_1",              1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 2'b01, 0, 3, 3, 2);
        add("wd_2",              1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 2'b10, 0, 4, 3, 2);
        add("wd_3",              1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 2'b10, 0, 5, 3, 2);
        add("wd_4",              1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 2'b10, 0, 6, 3, 2);
        add("wd_fired",          1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2'b10, 1, 7, 3, 2);
        add("stop_1",            1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b01, 1, 7, 3, 2);
        add("stop_2",            1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 1, 7, 3, 2);
        add("restart_stall",     1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 2'b00, 1, 7, 3, 2);
        add("rs_stall_1",        1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 2'b01, 1, 7, 3, 2);
        add("rs_stall_2",        1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 2'b10, 1, 8, 3, 2);
        add("async_rst",         0, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 2'b00, 0, 0, 0, 0);
        add("rst_release",       1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0, 0);
        add("run_after_rst",     1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2'b01, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst_n                 = vecs[i].rst;
            bus.start_i           = vecs[i].start;
            bus.ID_RS1addr_i      = vecs[i].rs1;
            bus.ID_RS2addr_i      = vecs[i].rs2;
            bus.ID_uses_rs2_i     = vecs[i].uses;
            bus.EX_MemRead_i      = vecs[i].mr;
            bus.EX_RDaddr_i       = vecs[i].rd;
            bus.ID_branch_taken_i = vecs[i].br;
            bus.mem_stall_i       = vecs[i].stall;
            exp_q.push_back(vecs[i]);
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain", "pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
    initial begin
        vec_t v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                chk(v.name, "PCWrite",    int'(bus.PCWrite_o),    int'(v.outs[4]));
                chk(v.name, "IFID_write", int'(bus.IFID_write_o), int'(v.outs[3]));
                chk(v.name, "IFID_flush", int'(bus.IFID_flush_o), int'(v.outs[2]));
                chk(v.name, "IDEX_start", int'(bus.IDEX_start_o), int'(v.outs[1]));
                chk(v.name, "pipe_hold",  int'(bus.pipe_hold_o),  int'(v.outs[0]));
                chk(v.name, "state",      int'(bus.state_o),      int'(v.st));
                chk(v.name, "timeout",    int'(bus.timeout_o),    int'(v.to));
`ifdef PIPE_CTRL_PERF_EN
                chk(v.name, "stall_cnt",  int'(bus.stall_cnt_o),  v.sc);
                chk(v.name, "bubble_cnt", int'(bus.bubble_cnt_o), v.bc);
                chk(v.name, "flush_cnt",  int'(bus.flush_cnt_o),  v.fc);
`endif
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: sim_time=%0t limit=20000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
